// File: rtl/zbb_pkg.sv
// Shared constants for the Zbb count-leading/trailing-zero helpers:
// mode encodings, decoder FSM states and per-mode seed words.
package zbb_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [1:0] MODE_LEAD_ONEHOT  = 2'd0;
  localparam logic [1:0] MODE_TRAIL_ONEHOT = 2'd1;
  localparam logic [1:0] MODE_LEAD_MASK    = 2'd2;
  localparam logic [1:0] MODE_TRAIL_MASK   = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic [XLEN-1:0] SEED_LEAD_ONEHOT  = 32'h8000_0000;
  localparam logic [XLEN-1:0] SEED_TRAIL_ONEHOT = 32'h0000_0001;
  localparam logic [XLEN-1:0] SEED_MASK         = 32'hFFFF_FFFF;

  function automatic logic [XLEN-1:0] seed_for_mode(input logic [1:0] mode);
    logic [XLEN-1:0] seed;
    case (mode)
      MODE_LEAD_ONEHOT:  seed = SEED_LEAD_ONEHOT;
      MODE_TRAIL_ONEHOT: seed = SEED_TRAIL_ONEHOT;
      default:           seed = SEED_MASK;
    endcase
    return seed;
  endfunction

  // Bit 0 of the mode selects the trailing (left-shifting) direction.
  function automatic logic mode_is_trail(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/clz_decoder_step.sv
// Combinational zero-filled shift by a small step, left for trailing modes
// and right for leading modes.
module clz_decoder_step
  import zbb_pkg::*;
#(
  parameter int STEP_W = 1
) (
  input  logic [XLEN-1:0]   data,
  input  logic              left,
  input  logic [STEP_W-1:0] step,
  output logic [XLEN-1:0]   result
);

  always_comb begin
    result = '0;
    if (left) result = data << step;
    else      result = data >> step;
  end

endmodule

// File: rtl/clz_decoder_seq.sv
// Iterative inverse of the clz/ctz encoder: builds a one-hot or mask word
// with a requested number of leading or trailing zeros.
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready high
// ST_SHIFT | shifting the seed until the remaining count reaches zero
// ST_DONE  | result presented, held until out_ready
module clz_decoder_seq
  import zbb_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic             out_err
);

  localparam int STEP_W = $clog2(SHIFT_PER_CYCLE) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(XLEN);

  state_t            state;
  logic [XLEN-1:0]   shreg;
  logic [CNT_W-1:0]  rem;
  logic [1:0]        mode_q;
  logic              err;

  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  rem_next;
  logic [XLEN-1:0]   shifted;

  always_comb begin
    step = STEP_W'(SHIFT_PER_CYCLE);
    if (rem < CNT_W'(SHIFT_PER_CYCLE)) step = rem[STEP_W-1:0];
    rem_next = rem - CNT_W'(step);
  end

  clz_decoder_step #(
    .STEP_W (STEP_W)
  ) u_step (
    .data   (shreg),
    .left   (mode_is_trail(mode_q)),
    .step   (step),
    .result (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      rem    <= '0;
      mode_q <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mode_q <= in_mode;
            rem    <= in_cnt;
            if (in_cnt > MAX_CNT) begin
              shreg <= '0;
              err   <= 1'b1;
              state <= ST_DONE;
            end else begin
              shreg <= seed_for_mode(in_mode);
              err   <= 1'b0;
              state <= (in_cnt == '0) ? ST_DONE : ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          shreg <= shifted;
          rem   <= rem_next;
          if (rem_next == '0) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
            err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = shreg;
  assign out_err   = err;

endmodule

// File: tb/tb_clz_decoder_seq.sv
// Bench for clz_decoder_seq: two instances (1 and 4 bits per cycle) share
// stimulus and are checked every cycle against an arithmetic model.
module tb_clz_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_cnt = '0;
  logic [1:0]  in_mode = '0;
  logic        out_ready = 1'b1;

  logic        in_ready1, out_valid1, out_err1;
  logic [31:0] out_data1;
  logic        in_ready4, out_valid4, out_err4;
  logic [31:0] out_data4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clz_decoder_seq #(.SHIFT_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_cnt(in_cnt), .in_mode(in_mode), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_err(out_err1)
  );

  clz_decoder_seq #(.SHIFT_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_cnt(in_cnt), .in_mode(in_mode), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_err(out_err4)
  );

  function automatic logic [31:0] model_data(input int cnt, input int mode);
    logic [63:0] w;
    if (cnt > 32) return 32'h0;
    case (mode)
      0:       w = 64'h8000_0000 >> cnt;
      1:       w = 64'h1 << cnt;
      2:       w = 64'hFFFF_FFFF >> cnt;
      default: w = 64'hFFFF_FFFF << cnt;
    endcase
    return w[31:0];
  endfunction

  // Edges counted from the accept edge inclusive until out_valid is seen.
  function automatic int model_lat(input int cnt, input int s);
    if (cnt == 0 || cnt > 32) return 1;
    return 1 + (cnt + s - 1) / s;
  endfunction

  function automatic int clz32(input logic [31:0] d);
    for (int i = 31; i >= 0; i--) if (d[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int ctz32(input logic [31:0] d);
    for (int i = 0; i < 32; i++) if (d[i]) return i;
    return 32;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  bit          pend[2];
  int          cyc[2];
  int          lat[2];
  logic [31:0] edata[2];
  logic        eerr[2];

  task automatic mon(input int idx, input bit acc, input bit hs, input int cnt, input int mode,
                     input logic ir, input logic ov, input logic oe, input logic [31:0] od);
    if (hs) pend[idx] = 1'b0;
    if (acc) begin
      pend[idx]  = 1'b1;
      cyc[idx]   = 0;
      lat[idx]   = model_lat(cnt, (idx == 0) ? 1 : 4);
      edata[idx] = model_data(cnt, mode);
      eerr[idx]  = (cnt > 32);
    end
    if (pend[idx]) begin
      cyc[idx]++;
      check($sformatf("valid_timing[%0d]", idx), 32'(ov), 32'(cyc[idx] >= lat[idx]));
      check($sformatf("ready_busy[%0d]", idx), 32'(ir), 32'h0);
      if (ov) begin
        check($sformatf("data[%0d]", idx), od, edata[idx]);
        check($sformatf("err[%0d]", idx), 32'(oe), 32'(eerr[idx]));
      end
    end else begin
      check($sformatf("ready_idle[%0d]", idx), 32'(ir), 32'h1);
      check($sformatf("valid_idle[%0d]", idx), 32'(ov), 32'h0);
    end
  endtask

  always @(posedge clk) begin
    bit a1, a4, h1, h4;
    int c, m;
    a1 = in_valid && in_ready1 && rst_n;
    a4 = in_valid && in_ready4 && rst_n;
    h1 = out_valid1 && out_ready && rst_n;
    h4 = out_valid4 && out_ready && rst_n;
    c  = int'(in_cnt);
    m  = int'(in_mode);
    #1;
    if (!rst_n) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      mon(0, a1, h1, c, m, in_ready1, out_valid1, out_err1, out_data1);
      mon(1, a4, h4, c, m, in_ready4, out_valid4, out_err4, out_data4);
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (in_ready1 && in_ready4) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: in_ready not seen within 100 cycles");
    end
  endtask

  task automatic req(input int cnt, input int mode, input logic [31:0] lit, input bit use_lit,
                     input bit rnd_ready, input string name,
                     output logic [31:0] d, output logic e);
    bit got;
    wait_idle();
    in_cnt   = cnt[5:0];
    in_mode  = mode[1:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_cnt   = 6'($urandom);
    in_mode  = 2'($urandom);
    got = 1'b0;
    d = '0;
    e = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (out_valid1) begin
        got = 1'b1;
        d = out_data1;
        e = out_err1;
        break;
      end
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: out_valid not seen within 80 cycles", name);
    end else if (use_lit) begin
      check(name, d, lit);
    end
  endtask

  initial begin
    logic [31:0] d, held;
    logic        e;

    repeat (3) @(negedge clk);
    check("reset_ready", 32'(in_ready1), 32'h1);
    check("reset_valid", 32'(out_valid1), 32'h0);
    check("reset_data", out_data1, 32'h0);
    check("reset_err", 32'(out_err1), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    req(23, 0, 32'h0000_0100, 1, 0, "lead_onehot_23", d, e);
    check("clz_invariant_23", 32'(clz32(d)), 32'd23);
    req(4, 1, 32'h0000_0010, 1, 0, "trail_onehot_4", d, e);
    check("ctz_invariant_4", 32'(ctz32(d)), 32'd4);
    req(1, 3, 32'hFFFF_FFFE, 1, 0, "trail_mask_1", d, e);
    req(0, 2, 32'hFFFF_FFFF, 1, 0, "lead_mask_0", d, e);
    req(32, 0, 32'h0000_0000, 1, 0, "lead_onehot_32", d, e);
    req(31, 2, 32'h0000_0001, 1, 0, "lead_mask_31", d, e);
    req(32, 1, 32'h0000_0000, 1, 0, "trail_onehot_32", d, e);
    req(32, 3, 32'h0000_0000, 1, 0, "trail_mask_32", d, e);
    req(40, 2, 32'h0000_0000, 1, 0, "err_40_data", d, e);
    check("err_40_flag", 32'(e), 32'h1);
    wait_idle();
    check("err_cleared", 32'(out_err1), 32'h0);

    // Backpressure: hold the result for 10 cycles, then release.
    wait_idle();
    out_ready = 1'b0;
    in_cnt = 6'd7;
    in_mode = 2'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid1; k++) @(negedge clk);
    held = out_data1;
    check("bp_data", held, 32'h01FF_FFFF);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_stable", out_data1, held);
      check("bp_ready_low", 32'(in_ready1), 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", 32'(in_ready1), 32'h1);
    req(9, 1, 32'h0000_0200, 1, 0, "after_bp", d, e);

    // Asynchronous reset in the middle of a long shift.
    wait_idle();
    in_cnt = 6'd20;
    in_mode = 2'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(in_ready1), 32'h1);
    check("rst_mid_valid", 32'(out_valid1), 32'h0);
    check("rst_mid_data", out_data1, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req(5, 1, 32'h0000_0020, 1, 0, "after_rst", d, e);

    for (int n = 0; n < 60; n++) begin
      int rc, rm;
      rc = int'($urandom_range(0, 40));
      rm = int'($urandom_range(0, 3));
      req(rc, rm, 32'h0, 0, 1, "random", d, e);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clz_decoder_seq.md
Name: clz_decoder_seq

Overview:
- Iterative inverse of the clz/ctz encoder.
- Takes a 6-bit zero count and a mode, and builds the 32-bit word that has exactly that many leading or trailing zeros, either as a one-hot word or as a mask.
- Used as the self-check generator for encoder benches and as a mask source for Zbb bit-field sequences in the execute stage.
- Valid/ready on input and output; one request in flight at a time.

Parameters:
- SHIFT_PER_CYCLE, 1, bit positions shifted per SHIFT cycle. Legal values are 1, 2, 4, 8.
- XLEN, 32, data width. Only 32 is supported; width of cnt is clog2(XLEN)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_cnt  in  6  zero count, 0..32 legal.
- in_mode  in  2  0=LEAD_ONEHOT, 1=TRAIL_ONEHOT, 2=LEAD_MASK, 3=TRAIL_MASK.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  decoded word.
- out_err  out  1  in_cnt was greater than 32.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state goes to IDLE; out_valid=0, out_data=0, out_err=0, in_ready=1.
  - The shift register and the remaining counter clear to 0.
  - Reset mid-operation abandons the request with no output.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - Handshake occurs when in_valid && in_ready at the edge. On handshake, seed and rem are loaded.
  - Seed per mode:
    - LEAD_ONEHOT = 0x80000000
    - TRAIL_ONEHOT = 0x00000001
    - LEAD_MASK = 0xFFFFFFFF
    - TRAIL_MASK = 0xFFFFFFFF
  - rem = in_cnt; mode is latched.
  - If in_cnt > 32: out_data=0, out_err=1, go to DONE.
  - Else if in_cnt == 0: go to DONE with the seed as the result.
  - Else: go to SHIFT.
- SHIFT (each cycle):
  - step = min(SHIFT_PER_CYCLE, rem). LEAD modes shift logically right by step; TRAIL modes shift left by step, zero-filled.
  - rem -= step. When the new rem == 0, go to DONE.
- DONE:
  - out_data and out_err are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE and clear out_err.
  - A new request is not accepted in the same cycle as the output handshake.
- Latency: accept at edge T gives out_valid high after edge T+1+ceil(cnt/SHIFT_PER_CYCLE), with cnt=0 giving T+1.
- Results (cnt=32 falls out of the shift with no special case):
  - LEAD_ONEHOT: bit (31-cnt) set; 0 when cnt=32.
  - TRAIL_ONEHOT: bit cnt set; 0 when cnt=32.
  - LEAD_MASK: 0xFFFFFFFF >> cnt.
  - TRAIL_MASK: 0xFFFFFFFF << cnt.
- in_cnt and in_mode are don't-care when in_valid=0. in_valid held while in_ready=0 has no effect.
- Invariant: for ONEHOT modes with cnt≤31, feeding out_data to the encoder returns cnt (for LEAD) or the ctz path returns cnt (for TRAIL).

Decomposition:
- Shared package (zbb_pkg) holds:
  - the mode encodings MODE_LEAD_ONEHOT..MODE_TRAIL_MASK;
  - the FSM state typedef;
  - the seed constants;
  - XLEN and CNT_W = clog2(XLEN)+1.
- One sub-module, clz_decoder_step: combinational shift-by-step for a given direction and step (≤ SHIFT_PER_CYCLE), instantiated once.
- The FSM, rem counter and handshake live in the top module.

Test Plan:
1. SHIFT_PER_CYCLE=1, LEAD_ONEHOT, cnt=23 → out_data=0x00000100, out_err=0, out_valid 24 cycles after accept; the encoder on out_data returns 23.
2. TRAIL_ONEHOT cnt=4 → 0x00000010. Then TRAIL_MASK cnt=1 → 0xFFFFFFFE. With SHIFT_PER_CYCLE=4, the cnt=4 case gives out_valid 2 cycles after accept.
3. Boundaries:
   - LEAD_MASK cnt=0 → 0xFFFFFFFF, latency 1.
   - LEAD_ONEHOT cnt=32 → 0x00000000, latency 33 at S=1.
   - LEAD_MASK cnt=31 → 0x00000001.
4. Error: cnt=40, any mode → out_data=0, out_err=1, latency 1; out_err clears after the output handshake.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_data stable, in_ready=0; release → IDLE next cycle, the next request is accepted and its result is correct.
6. Reset mid-operation: assert rst_n=0 during SHIFT of cnt=20 → out_valid=0 and in_ready=1 immediately (async); after release a new cnt=5 TRAIL_ONEHOT returns 0x00000020.
